// File: rtl/vga_timing_ctrl_if.sv
// Timing/handshake bundle between vga_timing_ctrl (master) and the pixel generator (slave).
// frame_cnt exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_ctrl_if;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       hsync_n;
  logic       vsync_n;
  logic       display_on;
  logic       line_start;
  logic       frame_start;
  logic       upd_req;
  logic       upd_ack;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  modport master (
    output hpos, vpos, hsync_n, vsync_n, display_on, line_start, frame_start, upd_ack,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output frame_cnt,
`endif
    input  upd_req
  );

  modport slave (
    input  hpos, vpos, hsync_n, vsync_n, display_on, line_start, frame_start, upd_ack,
`ifdef VGA_TIMING_FRAME_CNT_EN
    input  frame_cnt,
`endif
    output upd_req
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA frame sequencer: position counters, h/v phase FSMs, pipeline-aligned sync/enable,
// vblank config-update grant. Optional frame counter under VGA_TIMING_FRAME_CNT_EN.
//
// state   | meaning
// --------+-------------------------------------------
// HS_ACT  | visible pixels of the line
// HS_FP   | horizontal front porch
// HS_SYNC | hsync pulse (hsync low)
// HS_BP   | horizontal back porch
// VS_ACT  | visible lines of the frame
// VS_FP   | vertical front porch
// VS_SYNC | vsync pulse (vsync low)
// VS_BP   | vertical back porch
module vga_timing_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  vga_timing_ctrl_if.master  tif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_t;
  typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_t;

  h_state_t   h_state, h_state_nxt;
  v_state_t   v_state, v_state_nxt;
  logic [9:0] hpos_q, vpos_q, hpos_nxt, vpos_nxt;
  logic       h_wrap, v_wrap, step_line;
  logic       hsync_t, vsync_t, disp_t;
  logic [2:0] dly [0:PIPE_DELAY];
  logic       line_start_q, frame_start_q, upd_ack_q;

  always_comb begin
    h_wrap    = (hpos_q == H_LAST);
    v_wrap    = (vpos_q == V_LAST);
    step_line = ena && h_wrap;
    hpos_nxt  = hpos_q;
    vpos_nxt  = vpos_q;
    if (ena)       hpos_nxt = h_wrap ? '0 : hpos_q + 10'd1;
    if (step_line) vpos_nxt = v_wrap ? '0 : vpos_q + 10'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_state <= HS_ACT;
      v_state <= VS_ACT;
      hpos_q  <= '0;
      vpos_q  <= '0;
    end else begin
      h_state <= h_state_nxt;
      v_state <= v_state_nxt;
      hpos_q  <= hpos_nxt;
      vpos_q  <= vpos_nxt;
    end
  end

  // Phase follows the next position so the state always matches the registered counter.
  always_comb begin
    h_state_nxt = h_state;
    if (ena) begin
      case (h_state)
        HS_ACT:  if (hpos_nxt == H_FP_START)   h_state_nxt = HS_FP;
        HS_FP:   if (hpos_nxt == H_SYNC_START) h_state_nxt = HS_SYNC;
        HS_SYNC: if (hpos_nxt == H_BP_START)   h_state_nxt = HS_BP;
        HS_BP:   if (hpos_nxt == '0)           h_state_nxt = HS_ACT;
        default:                               h_state_nxt = HS_ACT;
      endcase
    end
    v_state_nxt = v_state;
    if (step_line) begin
      case (v_state)
        VS_ACT:  if (vpos_nxt == V_FP_START)   v_state_nxt = VS_FP;
        VS_FP:   if (vpos_nxt == V_SYNC_START) v_state_nxt = VS_SYNC;
        VS_SYNC: if (vpos_nxt == V_BP_START)   v_state_nxt = VS_BP;
        VS_BP:   if (vpos_nxt == '0)           v_state_nxt = VS_ACT;
        default:                               v_state_nxt = VS_ACT;
      endcase
    end
  end

  always_comb begin
    hsync_t = (h_state_nxt != HS_SYNC);
    vsync_t = (v_state_nxt != VS_SYNC);
    disp_t  = (h_state_nxt == HS_ACT) && (v_state_nxt == VS_ACT);
  end

  // dly[0] lines up with hpos/vpos; each further stage adds one pixel of delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= PIPE_DELAY; i++) dly[i] <= 3'b110;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      upd_ack_q     <= 1'b0;
    end else begin
      if (ena) begin
        dly[0] <= {hsync_t, vsync_t, disp_t};
        for (int i = 1; i <= PIPE_DELAY; i++) dly[i] <= dly[i-1];
      end
      line_start_q  <= step_line;
      frame_start_q <= step_line && v_wrap;
      upd_ack_q     <= step_line && (vpos_nxt == V_FP_START) && tif.upd_req;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  frame_cnt_q <= '0;
    else if (step_line && v_wrap) frame_cnt_q <= frame_cnt_q + 8'd1;
  end

  assign tif.frame_cnt = frame_cnt_q;
`endif

  assign tif.hpos        = hpos_q;
  assign tif.vpos        = vpos_q;
  assign tif.hsync_n     = dly[PIPE_DELAY][2];
  assign tif.vsync_n     = dly[PIPE_DELAY][1];
  assign tif.display_on  = dly[PIPE_DELAY][0];
  assign tif.line_start  = line_start_q;
  assign tif.frame_start = frame_start_q;
  assign tif.upd_ack     = upd_ack_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl using a shrunken raster; expected outputs come from
// an arithmetic model of the advance count since reset.
module tb_vga_timing_ctrl;
  localparam int HA = 16, HF = 4, HS = 6, HB = 5;
  localparam int VA = 12, VF = 2, VS = 3, VB = 4;
  localparam int PD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int F  = HT * VT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b0;

  vga_timing_ctrl_if tif();

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIPE_DELAY(PD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .tif(tif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h; int v;
    bit hs; bit vs; bit de;
    bit ls; bit fs; bit ack;
    int fc;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n     = 0;   // advancing cycles since reset release
  bit   req_r = 1'b0;

  function automatic bit m_hs(int k);
    int h = k % HT;
    return !(h >= HA + HF && h < HA + HF + HS);
  endfunction

  function automatic bit m_vs(int k);
    int v = (k / HT) % VT;
    return !(v >= VA + VF && v < VA + VF + VS);
  endfunction

  function automatic bit m_de(int k);
    return ((k % HT) < HA) && (((k / HT) % VT) < VA);
  endfunction

  function automatic exp_t expect_now(int k, bit adv, bit req);
    exp_t e;
    e.h   = k % HT;
    e.v   = (k / HT) % VT;
    e.hs  = (k > PD) ? m_hs(k - PD) : 1'b1;
    e.vs  = (k > PD) ? m_vs(k - PD) : 1'b1;
    e.de  = (k > PD) ? m_de(k - PD) : 1'b0;
    e.ls  = adv && (e.h == 0);
    e.fs  = adv && (e.h == 0) && (e.v == 0);
    e.ack = adv && (e.h == 0) && (e.v == VA) && req;
    e.fc  = (k / F) % 256;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s: got %0d, expected %0d (t=%0t, step %0d)", nm, act, req, $time, n);
    end
  endtask

  // Monitor: every cycle the DUT presents a registered output set, compare it to the queued one.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hpos",        32'(tif.hpos),        32'(e.h));
        chk("vpos",        32'(tif.vpos),        32'(e.v));
        chk("hsync_n",     32'(tif.hsync_n),     32'(e.hs));
        chk("vsync_n",     32'(tif.vsync_n),     32'(e.vs));
        chk("display_on",  32'(tif.display_on),  32'(e.de));
        chk("line_start",  32'(tif.line_start),  32'(e.ls));
        chk("frame_start", 32'(tif.frame_start), 32'(e.fs));
        chk("upd_ack",     32'(tif.upd_ack),     32'(e.ack));
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("frame_cnt",   32'(tif.frame_cnt),   32'(e.fc));
`endif
      end
    end
  end

  task automatic drive_cycle(input bit en, input bit rn, input bit raise);
    exp_t e;
    bit   adv;
    @(negedge clk);
    if (last_e.ack) req_r = 1'b0;
    if (raise)      req_r = 1'b1;
    if (!rn)        req_r = 1'b0;
    ena         = en;
    rst_n       = rn;
    tif.upd_req = req_r;
    adv = 1'b0;
    if (!rn) n = 0;
    else if (en) begin
      n++;
      adv = 1'b1;
    end
    e = expect_now(n, adv, req_r);
    last_e = e;
    exp_q.push_back(e);
  endtask

  task automatic run_to(input int target);
    int steps = ((target - (n % F)) % F + F) % F;
    for (int i = 0; i < steps; i++) drive_cycle(1'b1, 1'b1, 1'b0);
  endtask

  task automatic async_reset_check();
    exp_t e;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst hpos",        32'(tif.hpos),        32'd0);
    chk("rst vpos",        32'(tif.vpos),        32'd0);
    chk("rst hsync_n",     32'(tif.hsync_n),     32'd1);
    chk("rst vsync_n",     32'(tif.vsync_n),     32'd1);
    chk("rst display_on",  32'(tif.display_on),  32'd0);
    chk("rst line_start",  32'(tif.line_start),  32'd0);
    chk("rst frame_start", 32'(tif.frame_start), 32'd0);
    chk("rst upd_ack",     32'(tif.upd_ack),     32'd0);
    n = 0;
    req_r = 1'b0;
    tif.upd_req = 1'b0;
    e = expect_now(0, 1'b0, 1'b0);
    last_e = e;
    exp_q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tif.upd_req = 1'b0;
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0);

    // Two frames free-running: early request, then one raised just after the grant point.
    for (int i = 0; i < 2 * F + 50; i++)
      drive_cycle(1'b1, 1'b1,
                  (n < F && (n % F) == 5 * HT + 3) || ((n % F) == VA * HT + 5));

    // Freeze on the last visible pixel of a line.
    run_to((n / HT) % VT * HT + HA - 1);
    for (int i = 0; i < 50; i++) drive_cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b1, 1'b0);

    // Randomized enable gaps and request timing.
    for (int i = 0; i < 4000; i++) begin
      bit en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 299) == 0)
        for (int j = 0; j < 20; j++) drive_cycle(1'b0, 1'b1, 1'b0);
      drive_cycle(en, 1'b1, !req_r && ($urandom_range(0, 99) == 0));
    end

    // Asynchronous reset in the middle of a frame, then one full frame.
    run_to(7 * HT + 10);
    async_reset_check();
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < F + 5; i++) drive_cycle(1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 1000; i++)
      drive_cycle($urandom_range(0, 4) != 0, 1'b1, !req_r && ($urandom_range(0, 49) == 0));

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
